// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 128-bit line-wide memory port between the
// icache refill path and the dcache refill/write-back path, with a response watchdog.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         ic_req,
    input  logic [19:0]  ic_addr,
    output logic         ic_ack,
    output logic [127:0] ic_rdata,
    output logic         ic_err,

    input  logic         dc_req,
    input  logic         dc_we,
    input  logic [19:0]  dc_addr,
    input  logic [127:0] dc_wdata,
    output logic         dc_ack,
    output logic [127:0] dc_rdata,
    output logic         dc_err,

    output logic         mem_req,
    output logic         mem_we,
    output logic [19:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [19:0] LINE_MASK = 20'hFFFF0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state, state_nx;

    logic            grant_any;
    logic            grant_dc;
    logic            contention;
    logic            wd_expired;

    logic            owner_dc;
    logic            last_dc;
    logic [19:0]     addr_q;
    logic            we_q;
    logic [127:0]    wdata_q;
    logic [127:0]    rdata_q;
    logic            err_q;
    logic [WD_W-1:0] wd;

    // On a tie the requester that did not win the previous tie is granted.
    always_comb begin
        grant_any  = ic_req | dc_req;
        contention = ic_req & dc_req;
        grant_dc   = dc_req & ~(ic_req & last_dc);
        wd_expired = (wd == WD_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready || wd_expired) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Transaction context is captured at grant so requester inputs may change
    // freely while the port is owned.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_dc <= 1'b0;
            last_dc  <= 1'b1;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wd       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_dc <= grant_dc;
                        addr_q   <= (grant_dc ? dc_addr : ic_addr) & LINE_MASK;
                        we_q     <= grant_dc & dc_we;
                        wdata_q  <= grant_dc ? dc_wdata : '0;
                        rdata_q  <= '0;
                        err_q    <= 1'b0;
                        wd       <= '0;
                        if (contention) begin
                            last_dc <= grant_dc;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        rdata_q <= we_q ? '0 : mem_rdata;
                        err_q   <= 1'b0;
                    end else if (wd_expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ic_ack    = 1'b0;
        ic_rdata  = '0;
        ic_err    = 1'b0;
        dc_ack    = 1'b0;
        dc_rdata  = '0;
        dc_err    = 1'b0;
        case (state)
            BUSY: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                if (owner_dc) begin
                    dc_ack   = 1'b1;
                    dc_rdata = rdata_q;
                    dc_err   = err_q;
                end else begin
                    ic_ack   = 1'b1;
                    ic_rdata = rdata_q;
                    ic_err   = err_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a transaction-level
// model of grant order, line address, latency window and response data.
module tb_mem_arbiter;

    localparam int unsigned TO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req;
    logic [19:0]  ic_addr;
    logic         ic_ack;
    logic [127:0] ic_rdata;
    logic         ic_err;
    logic         dc_req;
    logic         dc_we;
    logic [19:0]  dc_addr;
    logic [127:0] dc_wdata;
    logic         dc_ack;
    logic [127:0] dc_rdata;
    logic         dc_err;
    logic         mem_req;
    logic         mem_we;
    logic [19:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    bit last_dc  = 1'b1;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_ack    (ic_ack),
        .ic_rdata  (ic_rdata),
        .ic_err    (ic_err),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_ack    (dc_ack),
        .dc_rdata  (dc_rdata),
        .dc_err    (dc_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] r128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_req"}, mem_req, 1'b0);
        check({tag, "_ic_ack"}, ic_ack, 1'b0);
        check({tag, "_dc_ack"}, dc_ack, 1'b0);
    endtask

    // Entered in an idle cycle with requests already presented; returns in the
    // idle cycle following the acknowledge. lat > TO means memory never answers.
    task automatic do_txn(input int lat, input logic [127:0] rd, input bit reassert);
        bit           exp_dc;
        bit           exp_err;
        logic [19:0]  src_addr;
        logic [19:0]  e_addr;
        bit           e_we;
        logic [127:0] e_wd;
        logic [127:0] e_rd;

        if (ic_req && dc_req) begin
            exp_dc  = !last_dc;
            last_dc = exp_dc;
        end else begin
            exp_dc = dc_req;
        end
        src_addr = exp_dc ? dc_addr : ic_addr;
        e_addr   = {src_addr[19:4], 4'h0};
        e_we     = exp_dc && dc_we;
        e_wd     = exp_dc ? dc_wdata : 128'h0;
        exp_err  = (lat > int'(TO));
        e_rd     = (exp_err || e_we) ? 128'h0 : rd;

        mem_ready = 1'b0;
        tick();
        for (int n = 1; n <= int'(TO); n++) begin
            check("busy_mem_req", mem_req, 1'b1);
            check("busy_mem_addr", mem_addr, e_addr);
            check("busy_mem_we", mem_we, e_we);
            check("busy_mem_wdata", mem_wdata, e_wd);
            check("busy_ic_ack", ic_ack, 1'b0);
            check("busy_dc_ack", dc_ack, 1'b0);
            if (exp_dc) begin
                dc_addr  = 20'($urandom());
                dc_wdata = r128();
                dc_we    = 1'($urandom());
            end else begin
                ic_addr = 20'($urandom());
            end
            if (n == lat) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_rdata = r128();
            end
            tick();
            mem_ready = 1'b0;
            if (n == lat) break;
        end

        check("resp_mem_req", mem_req, 1'b0);
        check("resp_ic_ack", ic_ack, !exp_dc);
        check("resp_dc_ack", dc_ack, exp_dc);
        check("resp_ic_rdata", ic_rdata, exp_dc ? 128'h0 : e_rd);
        check("resp_ic_err", ic_err, !exp_dc && exp_err);
        check("resp_dc_rdata", dc_rdata, exp_dc ? e_rd : 128'h0);
        check("resp_dc_err", dc_err, exp_dc && exp_err);

        if (exp_dc) begin
            dc_req   = reassert;
            dc_addr  = 20'($urandom());
            dc_wdata = r128();
        end else begin
            ic_req  = reassert;
            ic_addr = 20'($urandom());
        end
        mem_ready = 1'($urandom());
        mem_rdata = r128();
        tick();
        mem_ready = 1'b0;
        check_quiet("post_ack");
    endtask

    initial begin
        reset     = 1'b1;
        ic_req    = 1'b0;
        ic_addr   = '0;
        dc_req    = 1'b0;
        dc_we     = 1'b0;
        dc_addr   = '0;
        dc_wdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        check_quiet("reset");
        check("reset_mem_we", mem_we, 1'b0);
        check("reset_mem_addr", mem_addr, 20'h0);
        check("reset_mem_wdata", mem_wdata, 128'h0);
        check("reset_ic_rdata", ic_rdata, 128'h0);
        check("reset_dc_rdata", dc_rdata, 128'h0);
        check("reset_ic_err", ic_err, 1'b0);
        check("reset_dc_err", dc_err, 1'b0);
        reset = 1'b0;

        // Single icache read, memory answers on the 4th BUSY cycle.
        ic_req  = 1'b1;
        ic_addr = 20'h1234F;
        do_txn(4, {16{8'hA5}}, 1'b0);

        // Dcache write-back with one-cycle memory latency.
        dc_req   = 1'b1;
        dc_we    = 1'b1;
        dc_addr  = 20'hABCDE;
        dc_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
        do_txn(1, r128(), 1'b0);

        // Contention with both requesters continuously asking.
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        ic_addr = 20'($urandom());
        for (int i = 0; i < 4; i++) begin
            do_txn(int'($urandom_range(1, 3)), r128(), 1'b1);
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        tick();
        check_quiet("idle_no_req");

        // Timeout, then a normal transaction.
        ic_req  = 1'b1;
        ic_addr = 20'h00010;
        do_txn(TO + 1, r128(), 1'b0);
        dc_req = 1'b1;
        dc_we  = 1'b0;
        do_txn(2, r128(), 1'b0);

        // Memory answers on the last watchdog cycle.
        ic_req = 1'b1;
        do_txn(TO, r128(), 1'b0);

        // Reset one cycle into BUSY: icache wins a tie first, dcache then owns the port.
        ic_req = 1'b1;
        dc_req = 1'b1;
        do_txn(1, r128(), 1'b0);
        tick();
        check("rst_busy_mem_req", mem_req, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        check_quiet("rst_abort");
        reset   = 1'b0;
        last_dc = 1'b1;
        ic_req  = 1'b1;
        do_txn(3, r128(), 1'b0);
        do_txn(2, r128(), 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            int r;
            int lat;
            if (!ic_req && $urandom_range(0, 1) == 1) begin
                ic_req  = 1'b1;
                ic_addr = 20'($urandom());
            end
            if (!dc_req && $urandom_range(0, 1) == 1) begin
                dc_req   = 1'b1;
                dc_we    = 1'($urandom());
                dc_addr  = 20'($urandom());
                dc_wdata = r128();
            end
            if (!ic_req && !dc_req) begin
                ic_req  = 1'b1;
                ic_addr = 20'($urandom());
            end
            r = int'($urandom_range(0, 9));
            if (r < 2) lat = TO + 1;
            else if (r < 3) lat = TO;
            else lat = int'($urandom_range(1, TO - 1));
            do_txn(lat, r128(), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
